jtag_debug_cmd_bridge: RTL and testbench

- Parametrised system-clock-side receiver for the debug slave's virtual-JTAG command path.
- Synchronises the IR-update and DR-update strobes (vs_uir, vs_udr) from the TCK domain.
- Latches the IR and the shifted data register (sr), then presents one command at a time to the CPU debug logic over a valid/ready handshake.
- Replaces the fixed 2-bit-IR, 38-bit, fire-and-forget take_action decode. Adds generic width and channel count, backpressure, overrun/timeout detection and a command counter.

---
 rtl/jtag_debug_cmd_bridge.sv | 204 ++++++++++++++++++++
 tb/tb_jtag_debug_cmd_bridge.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_debug_cmd_bridge.sv
// rtl/jtag_debug_cmd_bridge.sv - system-clock receiver for the virtual-JTAG debug command path
//
// Synchronises the TCK-domain update-IR / update-DR strobes, latches the IR and the
// shifted data register, and presents one command at a time over a valid/ready
// handshake, with overrun / timeout status and an accepted-command counter.
//
// Optional feature macro: JTAG_DEBUG_CMD_PARITY_EN (even parity in sr[DATA_W-1],
// failing updates dropped, sticky parity_err output).
//
// Ports:
//   clk, reset      system clock, asynchronous active-high reset
//   sr, ir_in       TCK-domain data register / IR value (stable while strobes high)
//   vs_udr, vs_uir  asynchronous update-DR / update-IR levels
//   cmd_ready       consumer accepts the pending command
//   clr_status      one-cycle pulse clearing overrun / timeout (/ parity_err)
//   cmd_valid       a command is pending
//   cmd_ch, jdo     channel and data of the pending (or last) command
//   take_action     one-hot on cmd_ch when pending and jdo[ACT_BIT]=1
//   take_no_action  one-hot on cmd_ch when pending and jdo[ACT_BIT]=0
//   overrun         sticky: update arrived while a command was blocked
//   timeout         sticky: command dropped after TIMEOUT_CYC cycles
//   cmd_cnt         accepted-command counter (wraps)
//   parity_err      sticky parity failure (only with JTAG_DEBUG_CMD_PARITY_EN)

module jtag_debug_cmd_bridge #(
    parameter int IR_W        = 2,
    parameter int DATA_W      = 38,
    parameter int ACT_BIT     = 37,
    parameter int SYNC_STAGES = 3,
    parameter int TIMEOUT_CYC = 1024,
    parameter int CNT_W       = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_W-1:0]    sr,
    input  logic [IR_W-1:0]      ir_in,
    input  logic                 vs_udr,
    input  logic                 vs_uir,
    input  logic                 cmd_ready,
    input  logic                 clr_status,
    output logic                 cmd_valid,
    output logic [IR_W-1:0]      cmd_ch,
    output logic [DATA_W-1:0]    jdo,
    output logic [2**IR_W-1:0]   take_action,
    output logic [2**IR_W-1:0]   take_no_action,
    output logic                 overrun,
    output logic                 timeout,
    output logic [CNT_W-1:0]     cmd_cnt
`ifdef JTAG_DEBUG_CMD_PARITY_EN
    ,
    output logic                 parity_err
`endif
);

    localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TO_W-1:0] TO_LAST = (TIMEOUT_CYC > 0) ? TO_W'(TIMEOUT_CYC - 1) : '0;

    typedef enum logic {IDLE = 1'b0, PEND = 1'b1} state_t;

    state_t                   state_q, state_d;
    logic [SYNC_STAGES-1:0]   fill_q;
    logic [SYNC_STAGES-1:0]   udr_sync_q, uir_sync_q;
    logic                     udr_low_q, uir_low_q;
    logic                     udr_rise, uir_rise, udr_take;
    logic [IR_W-1:0]          ir_lat_q;
    logic [IR_W-1:0]          cmd_ch_q, cmd_ch_d;
    logic [DATA_W-1:0]        jdo_q, jdo_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [TO_W-1:0]          to_q, to_d;
    logic                     ovr_q, ovr_d, tmo_q, tmo_d;
    logic                     to_hit, load;

    // fill_q marks when the synchroniser outputs carry real post-reset samples.
    // The low flags only arm on a genuine 0 at the pin, so a strobe already high
    // when reset releases never produces an edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fill_q     <= '0;
            udr_sync_q <= '0;
            uir_sync_q <= '0;
            udr_low_q  <= 1'b0;
            uir_low_q  <= 1'b0;
            ir_lat_q   <= '0;
        end else begin
            fill_q     <= {fill_q[SYNC_STAGES-2:0], 1'b1};
            udr_sync_q <= {udr_sync_q[SYNC_STAGES-2:0], vs_udr};
            uir_sync_q <= {uir_sync_q[SYNC_STAGES-2:0], vs_uir};
            udr_low_q  <= fill_q[SYNC_STAGES-1] & ~udr_sync_q[SYNC_STAGES-1];
            uir_low_q  <= fill_q[SYNC_STAGES-1] & ~uir_sync_q[SYNC_STAGES-1];
            if (uir_rise) begin
                ir_lat_q <= ir_in;
            end
        end
    end

    assign udr_rise = udr_sync_q[SYNC_STAGES-1] & udr_low_q;
    assign uir_rise = uir_sync_q[SYNC_STAGES-1] & uir_low_q;

`ifdef JTAG_DEBUG_CMD_PARITY_EN
    logic par_ok, par_q;
    assign par_ok   = ~^sr;
    assign udr_take = udr_rise & par_ok;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            par_q <= 1'b0;
        end else begin
            par_q <= (par_q & ~clr_status) | (udr_rise & ~par_ok);
        end
    end
    assign parity_err = par_q;
`else
    assign udr_take = udr_rise;
`endif

    assign to_hit = (TIMEOUT_CYC != 0) && (to_q == TO_LAST);

    always_comb begin
        state_d  = state_q;
        jdo_d    = jdo_q;
        cmd_ch_d = cmd_ch_q;
        cnt_d    = cnt_q;
        to_d     = to_q;
        ovr_d    = ovr_q & ~clr_status;
        tmo_d    = tmo_q & ~clr_status;
        load     = 1'b0;
        case (state_q)
            IDLE: begin
                if (udr_take) begin
                    state_d = PEND;
                    load    = 1'b1;
                end
            end
            PEND: begin
                if (cmd_ready) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (udr_take) begin
                        load = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    // Blocked: a new update is lost; the timeout keeps running.
                    if (udr_take) begin
                        ovr_d = 1'b1;
                    end
                    if (to_hit) begin
                        state_d = IDLE;
                        tmo_d   = 1'b1;
                    end else if (TIMEOUT_CYC != 0) begin
                        to_d = to_q + TO_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // ir_lat_q is the pre-update value, so a coincident IR update applies next time.
        if (load) begin
            jdo_d    = sr;
            cmd_ch_d = ir_lat_q;
            to_d     = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            jdo_q    <= '0;
            cmd_ch_q <= '0;
            cnt_q    <= '0;
            to_q     <= '0;
            ovr_q    <= 1'b0;
            tmo_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            jdo_q    <= jdo_d;
            cmd_ch_q <= cmd_ch_d;
            cnt_q    <= cnt_d;
            to_q     <= to_d;
            ovr_q    <= ovr_d;
            tmo_q    <= tmo_d;
        end
    end

    always_comb begin
        take_action    = '0;
        take_no_action = '0;
        if (state_q == PEND) begin
            if (jdo_q[ACT_BIT]) begin
                take_action[cmd_ch_q] = 1'b1;
            end else begin
                take_no_action[cmd_ch_q] = 1'b1;
            end
        end
    end

    assign cmd_valid = (state_q == PEND);
    assign cmd_ch    = cmd_ch_q;
    assign jdo       = jdo_q;
    assign cmd_cnt   = cnt_q;
    assign overrun   = ovr_q;
    assign timeout   = tmo_q;

endmodule

// File: tb/tb_jtag_debug_cmd_bridge.sv
// tb/tb_jtag_debug_cmd_bridge.sv - scoreboard bench for jtag_debug_cmd_bridge
module tb_jtag_debug_cmd_bridge;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [37:0] sr = '0;
    logic [1:0]  ir_in = '0;
    logic        vs_udr = 1'b0, vs_uir = 1'b0, cmd_ready = 1'b0, clr_status = 1'b0;
    logic        cmd_valid, overrun, timeout;
    logic [1:0]  cmd_ch;
    logic [37:0] jdo;
    logic [3:0]  take_action, take_no_action;
    logic [15:0] cmd_cnt;

    always #5 clk = ~clk;

    jtag_debug_cmd_bridge #(.TIMEOUT_CYC(TO)) dut (
        .clk(clk), .reset(reset), .sr(sr), .ir_in(ir_in),
        .vs_udr(vs_udr), .vs_uir(vs_uir), .cmd_ready(cmd_ready), .clr_status(clr_status),
        .cmd_valid(cmd_valid), .cmd_ch(cmd_ch), .jdo(jdo),
        .take_action(take_action), .take_no_action(take_no_action),
        .overrun(overrun), .timeout(timeout), .cmd_cnt(cmd_cnt)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Reference model: strobe pin histories since reset, one pending command slot.
    typedef struct {logic [37:0] d; logic [1:0] ch;} cmd_t;
    cmd_t        exp_q[$];
    bit          udr_h[$], uir_h[$];
    bit          m_pend = 0, m_ovr = 0, m_tmo = 0;
    logic [37:0] m_jdo = '0;
    logic [1:0]  m_ch = '0, m_ir = '0;
    logic [15:0] m_cnt = '0;
    int          m_age = 0;

    initial begin
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                m_pend = 0; m_ovr = 0; m_tmo = 0; m_jdo = '0; m_ch = '0; m_ir = '0;
                m_cnt = '0; m_age = 0;
                udr_h.delete(); uir_h.delete(); exp_q.delete();
            end else begin
                int  n;
                bit  ur, ir, ld;
                udr_h.push_back(vs_udr);
                uir_h.push_back(vs_uir);
                n  = udr_h.size();
                // A pin edge takes effect at the SYNC_STAGES+1'th clock after it is
                // sampled, and only once a real low sample precedes the high one.
                ur = (n >= 5) && udr_h[n-4] && !udr_h[n-5];
                ir = (n >= 5) && uir_h[n-4] && !uir_h[n-5];
                ld = 0;
                if (clr_status) begin m_ovr = 0; m_tmo = 0; end
                if (!m_pend) begin
                    ld = ur;
                end else if (cmd_ready) begin
                    m_cnt++;
                    if (ur) ld = 1; else m_pend = 0;
                end else begin
                    if (ur) m_ovr = 1;
                    if (m_age == TO - 1) begin m_pend = 0; m_tmo = 1; end
                    else m_age++;
                end
                if (ld) begin
                    m_pend = 1; m_jdo = sr; m_ch = m_ir; m_age = 0;
                    exp_q.push_back('{sr, m_ir});
                end
                if (ir) m_ir = ir_in;
            end
        end
    end

    // Monitor: checks every presented command against the scoreboard and the
    // status outputs against the model.
    initial begin
        bit pv, ph;
        pv = 0; ph = 0;
        forever begin
            logic [3:0] eta, etn;
            @(negedge clk);
            eta = (m_pend &&  m_jdo[37]) ? 4'(1 << m_ch) : 4'd0;
            etn = (m_pend && !m_jdo[37]) ? 4'(1 << m_ch) : 4'd0;
            check("status", {cmd_valid, cmd_cnt, overrun, timeout, take_action, take_no_action, cmd_ch},
                            {m_pend, m_cnt, m_ovr, m_tmo, eta, etn, m_ch});
            check("jdo", jdo, m_jdo);
            if (cmd_valid && (!pv || ph)) begin
                check("sb_nonempty", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    cmd_t e;
                    e = exp_q.pop_front();
                    check("sb_jdo", jdo, e.d);
                    check("sb_ch", cmd_ch, e.ch);
                end
            end
            pv = cmd_valid;
            ph = cmd_valid && cmd_ready;
        end
    end

    int          rdy_pct = 100;
    int          lat;
    logic [37:0] cap_jdo;
    logic [1:0]  cap_ch;
    logic [3:0]  cap_ta, cap_tn;

    // mode 0: hold controls, 1: random ready/clr, 2: ready only on the edge-effective cycle
    task automatic drive_ctl(input int mode, input int i);
        if (mode == 1) begin
            cmd_ready  = ($urandom_range(0, 99) < rdy_pct);
            clr_status = ($urandom_range(0, 39) == 0);
        end else begin
            clr_status = 1'b0;
            if (mode == 2) cmd_ready = (i == 3);
        end
    endtask

    task automatic step(input int n, input int mode);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            drive_ctl(mode, 99);
        end
    endtask

    task automatic pulse(input bit du, input bit di, input logic [37:0] d,
                         input logic [1:0] ir, input int mode);
        bit was_valid;
        was_valid = cmd_valid;
        lat = -1;
        sr = d; ir_in = ir; vs_udr = du; vs_uir = di;
        drive_ctl(mode, 0);
        for (int i = 1; i <= 9; i++) begin
            @(posedge clk); #1;
            if (du && !was_valid && lat < 0 && cmd_valid) begin
                lat = i; cap_jdo = jdo; cap_ch = cmd_ch; cap_ta = take_action; cap_tn = take_no_action;
            end
            if (i == 5) begin vs_udr = 1'b0; vs_uir = 1'b0; end
            drive_ctl(mode, i);
        end
    endtask

    initial begin
        logic [63:0] r;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", cmd_valid, 0);
        check("rst_cnt", cmd_cnt, 0);
        reset = 1'b0;
        step(6, 0);

        // take_action on channel 1
        cmd_ready = 1'b1;
        pulse(0, 1, '0, 2'b01, 0);
        pulse(1, 0, 38'h20_0000_1234, 2'b00, 0);
        check("t1_latency", lat, 4);
        check("t1_ch", cap_ch, 1);
        check("t1_ta", cap_ta, 4'b0010);
        check("t1_tn", cap_tn, 4'b0000);
        check("t1_jdo", cap_jdo, 38'h20_0000_1234);
        check("t1_cnt", cmd_cnt, 1);

        // take_no_action on channel 3
        pulse(0, 1, '0, 2'b11, 0);
        pulse(1, 0, 38'h00_0000_5678, 2'b00, 0);
        check("t2_tn", cap_tn, 4'b1000);
        check("t2_ta", cap_ta, 4'b0000);
        check("t2_cnt", cmd_cnt, 2);

        // overrun while blocked, then timeout
        cmd_ready = 1'b0;
        pulse(1, 0, 38'h3F_1111_2222, 2'b00, 0);
        pulse(1, 0, 38'h01_3333_4444, 2'b00, 0);
        check("t3_valid", cmd_valid, 1);
        check("t3_jdo_held", jdo, 38'h3F_1111_2222);
        check("t3_overrun", overrun, 1);
        clr_status = 1'b1;
        step(1, 0);
        check("t3_clr", overrun, 0);
        step(4, 0);
        check("t4_timeout", timeout, 1);
        check("t4_valid", cmd_valid, 0);
        check("t4_cnt", cmd_cnt, 2);
        clr_status = 1'b1;
        step(1, 0);
        check("t4_clr", timeout, 0);

        // ready coincident with the second update: handshake plus reload
        pulse(1, 0, 38'h2A_AAAA_0001, 2'b00, 0);
        pulse(1, 0, 38'h15_5555_0002, 2'b00, 2);
        check("t5_cnt", cmd_cnt, 3);
        check("t5_valid", cmd_valid, 1);
        check("t5_jdo", jdo, 38'h15_5555_0002);
        check("t5_overrun", overrun, 0);
        cmd_ready = 1'b1;
        step(2, 0);
        check("t5_cnt2", cmd_cnt, 4);

        // asynchronous reset mid-command, released with vs_udr high
        cmd_ready = 1'b0;
        pulse(1, 0, 38'h22_0000_00FF, 2'b00, 0);
        @(posedge clk); #3;
        reset = 1'b1; vs_udr = 1'b1;
        #1;
        check("t6_valid", cmd_valid, 0);
        check("t6_cnt", cmd_cnt, 0);
        check("t6_jdo", jdo, 0);
        check("t6_ta", take_action, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        step(15, 0);
        check("t6_no_edge", cmd_valid, 0);
        vs_udr = 1'b0; cmd_ready = 1'b1;
        step(3, 0);
        pulse(1, 0, 38'h20_0000_0777, 2'b00, 0);
        check("t6_latency", lat, 4);
        check("t6_cnt", cmd_cnt, 1);

        // randomized traffic
        for (int it = 0; it < 250; it++) begin
            int op;
            case ($urandom_range(0, 3))
                0: rdy_pct = 0;
                1: rdy_pct = 30;
                2: rdy_pct = 70;
                default: rdy_pct = 100;
            endcase
            op = $urandom_range(0, 3);
            r = {$urandom(), $urandom()};
            case (op)
                0: pulse(1, 0, r[37:0], 2'($urandom_range(0, 3)), 1);
                1: pulse(0, 1, r[37:0], 2'($urandom_range(0, 3)), 1);
                2: pulse(1, 1, r[37:0], 2'($urandom_range(0, 3)), 1);
                default: step($urandom_range(1, 20), 1);
            endcase
            step($urandom_range(0, 6), 1);
        end

        clr_status = 1'b0; cmd_ready = 1'b1;
        step(25, 0);
        check("sb_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
